// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit path behind the UART data register. Bytes written by the CPU are
// queued in a small FIFO and shifted out on txd as 8N1 frames (start bit,
// 8 data bits LSB first, stop bit). Each bit lasts CLK_DIV clock cycles.
// When a stop bit ends with another byte queued, the next start bit follows
// immediately, so there is no idle gap between frames.
//
// Parameters
//   CLK_DIV     clock cycles per serial bit (>= 2)
//   FIFO_DEPTH  queued bytes (power of two, >= 2)
//
// Ports
//   clk        in   system clock, all state updates on posedge
//   reset      in   asynchronous active-high reset, clears all state
//   data_in    in   [7:0] byte to enqueue, sampled when wr_en=1
//   wr_en      in   enqueue strobe, one byte per posedge
//   status_rd  in   status register read, clears overflow
//   txd        out  serial line, idle high
//   tx_empty   out  FIFO empty
//   tx_full    out  FIFO holds FIFO_DEPTH bytes
//   tx_busy    out  frame in progress
//   overflow   out  sticky: a write arrived while full and not popped
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       wr_en,
   input  logic       status_rd,
   output logic       txd,
   output logic       tx_empty,
   output logic       tx_full,
   output logic       tx_busy,
   output logic       overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BCNT_MAX = BW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_reg;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic [BW-1:0] bcnt_reg;
   logic [2:0]    idx_reg;
   logic [7:0]    shift_reg;
   logic          txd_reg;
   logic          empty_reg;
   logic          full_reg;
   logic          busy_reg;
   logic          ovf_reg;

   logic          bit_end;
   logic          pop;
   logic          push;
   logic          ovf_set;

   // A pop happens either from IDLE or on the last cycle of a stop bit, so a
   // write that lands on a full FIFO on that same edge still finds room.
   always_comb begin
      bit_end    = (bcnt_reg == BCNT_MAX);
      pop        = (count_reg != '0) &&
                   ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));
      push       = wr_en && ((count_reg != DEPTH_C) || pop);
      ovf_set    = wr_en && !push;
      count_next = count_reg;
      if (push && !pop) begin
         count_next = count_reg + 1'b1;
      end else if (pop && !push) begin
         count_next = count_reg - 1'b1;
      end
   end

   // Queue storage carries no reset: stale contents are never read because
   // count gates every pop.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         bcnt_reg   <= '0;
         idx_reg    <= '0;
         shift_reg  <= '0;
         txd_reg    <= 1'b1;
         empty_reg  <= 1'b1;
         full_reg   <= 1'b0;
         busy_reg   <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         count_reg <= count_next;
         empty_reg <= (count_next == '0);
         full_reg  <= (count_next == DEPTH_C);
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         // Set wins over the clear when both happen on one edge.
         if (ovf_set) begin
            ovf_reg <= 1'b1;
         end else if (status_rd) begin
            ovf_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (pop) begin
                  shift_reg <= mem[rd_ptr_reg];
                  txd_reg   <= 1'b0;
                  bcnt_reg  <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  txd_reg   <= shift_reg[0];
                  idx_reg   <= '0;
                  bcnt_reg  <= '0;
                  state_reg <= DATA;
               end else begin
                  bcnt_reg <= bcnt_reg + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  bcnt_reg <= '0;
                  if (idx_reg == 3'd7) begin
                     txd_reg   <= 1'b1;
                     state_reg <= STOP;
                  end else begin
                     shift_reg <= shift_reg >> 1;
                     txd_reg   <= shift_reg[1];
                     idx_reg   <= idx_reg + 3'd1;
                  end
               end else begin
                  bcnt_reg <= bcnt_reg + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  bcnt_reg <= '0;
                  if (pop) begin
                     shift_reg <= mem[rd_ptr_reg];
                     txd_reg   <= 1'b0;
                     state_reg <= START;
                  end else begin
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end
               end else begin
                  bcnt_reg <= bcnt_reg + 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign txd      = txd_reg;
   assign tx_empty = empty_reg;
   assign tx_full  = full_reg;
   assign tx_busy  = busy_reg;
   assign overflow = ovf_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Bench for uart_tx_serializer with CLK_DIV=4, FIFO_DEPTH=4. A reference model
// keeps the queued bytes in a queue plus a "cycles left in the current frame"
// countdown; the expected txd level is derived from the position inside the
// frame. Every cycle, all outputs are compared with the model.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

   localparam int CD    = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CD;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       wr_en;
   logic       status_rd;
   logic       txd;
   logic       tx_empty;
   logic       tx_full;
   logic       tx_busy;
   logic       overflow;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   logic [7:0] m_q[$];
   int         m_left = 0;
   logic [7:0] m_cur  = 8'h00;
   logic       m_ovf  = 1'b0;

   uart_tx_serializer #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .wr_en     (wr_en),
      .status_rd (status_rd),
      .txd       (txd),
      .tx_empty  (tx_empty),
      .tx_full   (tx_full),
      .tx_busy   (tx_busy),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_left = 0;
      m_ovf  = 1'b0;
   endtask

   // One clock edge of the transmitter, described by frame timing:
   // a byte is taken when the line is free (idle, or the final stop cycle).
   task automatic model_edge(input logic wr, input logic [7:0] d, input logic srd);
      bit pop;
      bit acc;
      pop = (m_q.size() > 0) && (m_left <= 1);
      acc = wr && ((m_q.size() < DEPTH) || pop);
      if (pop) begin
         m_cur  = m_q.pop_front();
         m_left = FRAME;
         $display("frame start byte=%02h t=%0t", m_cur, $time);
      end else if (m_left > 0) begin
         m_left--;
      end
      if (acc) m_q.push_back(d);
      if (wr && !acc) m_ovf = 1'b1;
      else if (srd) m_ovf = 1'b0;
   endtask

   function automatic logic exp_txd();
      int pos;
      int b;
      if (m_left == 0) return 1'b1;
      pos = FRAME - m_left;
      b   = pos / CD;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_cur[b-1];
   endfunction

   task automatic check_all();
      chk("txd",      txd,      exp_txd());
      chk("tx_busy",  tx_busy,  m_left > 0);
      chk("tx_empty", tx_empty, m_q.size() == 0);
      chk("tx_full",  tx_full,  m_q.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
   endtask

   task automatic step(input logic wr, input logic [7:0] d, input logic srd);
      wr_en     = wr;
      data_in   = d;
      status_rd = srd;
      @(posedge clk);
      model_edge(wr, d, srd);
      #1;
      check_all();
      wr_en     = 1'b0;
      status_rd = 1'b0;
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      while ((m_left > 0 || m_q.size() > 0) && guard < 2000) begin
         step(1'b0, 8'h00, 1'b0);
         guard++;
      end
      chk_int(tag, m_left + m_q.size(), 0);
   endtask

   initial begin
      int busy_cnt;
      int guard;
      int sent;

      reset     = 1'b1;
      wr_en     = 1'b0;
      data_in   = 8'h00;
      status_rd = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_txd",   txd,      1'b1);
      chk("rst_empty", tx_empty, 1'b1);
      chk("rst_full",  tx_full,  1'b0);
      chk("rst_busy",  tx_busy,  1'b0);
      chk("rst_ovf",   overflow, 1'b0);
      reset = 1'b0;
      step(1'b0, 8'h00, 1'b0);

      // T1 single byte 0xA5: busy for exactly one frame
      step(1'b1, 8'hA5, 1'b0);
      chk("t1_empty_after_write", tx_empty, 1'b0);
      busy_cnt = 0;
      for (int i = 0; i < FRAME + 5; i++) begin
         step(1'b0, 8'h00, 1'b0);
         if (tx_busy) busy_cnt++;
      end
      chk_int("t1_busy_cycles", busy_cnt, FRAME);

      // T2 back-to-back 0x00, 0xFF: two frames with no idle gap
      step(1'b1, 8'h00, 1'b0);
      step(1'b1, 8'hFF, 1'b0);
      busy_cnt = 1;
      for (int i = 0; i < 2 * FRAME + 5; i++) begin
         step(1'b0, 8'h00, 1'b0);
         if (tx_busy) busy_cnt++;
      end
      chk_int("t2_busy_cycles", busy_cnt, 2 * FRAME);

      // T3 six fast writes: four queue up, the sixth is dropped
      for (int i = 0; i < 6; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
      chk("t3_full", tx_full,  1'b1);
      chk("t3_ovf",  overflow, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("t3_ovf_clear", overflow, 1'b0);
      drain("t3_drain");

      // T4 write into a full FIFO on the edge that pops it
      for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
      guard = 0;
      while (m_left != 1 && guard < 200) begin
         step(1'b0, 8'h00, 1'b0);
         guard++;
      end
      chk_int("t4_reach_pop_edge", m_left, 1);
      step(1'b1, 8'hC9, 1'b0);
      chk("t4_ovf",  overflow, 1'b0);
      chk("t4_full", tx_full,  1'b1);
      drain("t4_drain");

      // T5 asynchronous reset during data bit 3
      step(1'b1, 8'h3C, 1'b0);
      step(1'b1, 8'h5A, 1'b0);
      guard = 0;
      while (!(m_left > 0 && (FRAME - m_left) == 4 * CD + 1) && guard < 200) begin
         step(1'b0, 8'h00, 1'b0);
         guard++;
      end
      chk("t5_empty_before", tx_empty, 1'b0);
      #1;
      reset = 1'b1;
      #1;
      chk("t5_txd",   txd,      1'b1);
      chk("t5_busy",  tx_busy,  1'b0);
      chk("t5_empty", tx_empty, 1'b1);
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;
      step(1'b1, 8'h96, 1'b0);
      drain("t5_drain");

      // T6 stream 0x01..0x14 paced by tx_full
      sent  = 0;
      guard = 0;
      while (sent < 20 && guard < 2000) begin
         if (!tx_full) begin
            step(1'b1, 8'(sent + 1), 1'b0);
            sent++;
         end else begin
            step(1'b0, 8'h00, 1'b0);
         end
         guard++;
      end
      chk_int("t6_sent", sent, 20);
      chk("t6_ovf", overflow, 1'b0);
      drain("t6_drain");

      // Random traffic with occasional status reads
      for (int i = 0; i < 500; i++) begin
         step(logic'($urandom_range(0, 1)), 8'($urandom), logic'($urandom_range(0, 19) == 0));
      end
      drain("rand_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
